// File: rtl/sdram_word_adapter.sv
// Splits each 32-bit CPU word access into byte-wide sdram_controller transactions,
// reassembling read data little-endian and acknowledging with one o_ack pulse.
module sdram_word_adapter #(
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [22:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy,
  output logic        o_sd_request,
  output logic        o_sd_wren,
  output logic [22:0] o_sd_address,
  output logic [7:0]  o_sd_data,
  input  logic [7:0]  i_sd_data,
  input  logic        i_sd_done
);

  localparam int            TW       = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, NEXT, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic          we_q;
  logic [20:0]   base_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    lane_q;
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic [2:0]    next_lane;

  // Lowest enabled lane at or above the current one; 4 means nothing left to do.
  // NOTE: the default before the loop keeps this purely combinational (no latch).
  always_comb begin
    next_lane = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (be_q[k] && (3'(k) >= lane_q)) next_lane = 3'(k);
    end
  end

  // NOTE: all state and outputs are registered with non-blocking assignments and
  // cleared by the asynchronous reset, so an abort takes effect without a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      base_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      lane_q       <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      o_rdata      <= '0;
      o_ack        <= 1'b0;
      o_err        <= 1'b0;
      o_busy       <= 1'b0;
      o_sd_request <= 1'b0;
      o_sd_wren    <= 1'b0;
      o_sd_address <= '0;
      o_sd_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            we_q    <= i_we;
            base_q  <= i_addr[22:2];
            be_q    <= i_we ? i_be : 4'b1111;
            wdata_q <= i_wdata;
            lane_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            o_busy  <= 1'b1;
            state   <= NEXT;
          end
        end
        NEXT: begin
          if (next_lane[2]) begin
            o_ack <= 1'b1;
            o_err <= err_q;
            state <= DONE;
          end else begin
            lane_q       <= next_lane;
            tmo_q        <= '0;
            o_sd_request <= 1'b1;
            o_sd_wren    <= we_q;
            o_sd_address <= {base_q, next_lane[1:0]};
            o_sd_data    <= wdata_q[8*next_lane[1:0] +: 8];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          o_sd_request <= 1'b0;
          state        <= WAIT;
        end
        WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          // A done arriving on the last allowed cycle still completes the byte.
          if (i_sd_done) begin
            if (!we_q) o_rdata[8*lane_q[1:0] +: 8] <= i_sd_data;
            lane_q <= lane_q + 3'd1;
            state  <= NEXT;
          end else if (tmo_q == TMO_LAST) begin
            err_q <= 1'b1;
            o_ack <= 1'b1;
            o_err <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          o_ack  <= 1'b0;
          o_err  <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_word_adapter.sv
// Randomized bench for sdram_word_adapter: a byte-wide SDRAM responder with random
// latency plus a word-level model predicting requests, read data, error and ack time.
module tb_sdram_word_adapter;

  localparam int TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic        i_we;
  logic [22:0] i_addr;
  logic [3:0]  i_be;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_err;
  logic        o_busy;
  logic        sd_request;
  logic        sd_wren;
  logic [22:0] sd_address;
  logic [7:0]  sd_wdata;
  logic [7:0]  sd_rdata;
  logic        sd_done;

  sdram_word_adapter #(.DONE_TIMEOUT(TMO)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_be         (i_be),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_ack        (o_ack),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_sd_request (sd_request),
    .o_sd_wren    (sd_wren),
    .o_sd_address (sd_address),
    .o_sd_data    (sd_wdata),
    .i_sd_data    (sd_rdata),
    .i_sd_done    (sd_done)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h100:   return 8'h11;
      'h101:   return 8'h22;
      'h102:   return 8'h33;
      'h103:   return 8'h44;
      default: return 8'((i * 37 + 5) & 'hFF);
    endcase
  endfunction

  // Controller responder: SDRAM image folded onto 1 KiB, done after lat cycles.
  logic [7:0]  sd_mem [0:1023];
  bit          no_done = 1'b0;
  int          lat_min = 1;
  int          lat_max = 4;
  int          stray_req = 0;
  logic [22:0] log_addr[$];
  logic        log_wren[$];
  logic [7:0]  log_data[$];
  int          log_lat[$];
  int          long_pulses = 0;
  int          unstable = 0;

  initial begin : ctrl_model
    logic [22:0] p_addr;
    logic        p_wren;
    logic [7:0]  p_data;
    int          cnt;
    bit          pending;
    bit          req_prev;
    int          stray_seen;
    for (int i = 0; i < 1024; i++) sd_mem[i] = init_byte(i);
    sd_done = 1'b0;
    sd_rdata = 8'h00;
    pending = 1'b0;
    req_prev = 1'b0;
    stray_seen = 0;
    cnt = 0;
    p_addr = '0;
    p_wren = 1'b0;
    p_data = '0;
    forever begin
      @(posedge i_clk);
      #1;
      sd_done = 1'b0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        sd_done = 1'b1;
      end
      if (pending) begin
        if (o_busy && (sd_address !== p_addr || sd_wren !== p_wren || sd_wdata !== p_data))
          unstable++;
        cnt--;
        if (cnt == 0) begin
          pending = 1'b0;
          sd_done = 1'b1;
          if (p_wren) sd_mem[p_addr[9:0]] = p_data;
          else        sd_rdata = sd_mem[p_addr[9:0]];
        end
      end
      if (sd_request) begin
        if (req_prev) long_pulses++;
        p_addr = sd_address;
        p_wren = sd_wren;
        p_data = sd_wdata;
        log_addr.push_back(sd_address);
        log_wren.push_back(sd_wren);
        log_data.push_back(sd_wdata);
        if (!no_done) begin
          pending = 1'b1;
          cnt = int'($urandom_range(lat_max, lat_min));
          log_lat.push_back(cnt);
        end else begin
          log_lat.push_back(0);
        end
      end
      req_prev = sd_request;
    end
  end

  // Word-level reference: expected memory image and expected o_rdata.
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_rdata = '0;
  int          last_acc;
  int          last_ack;

  task automatic check_reset_values(input string tag);
    check({tag, "_rdata"},   o_rdata, 0);
    check({tag, "_ack"},     o_ack, 0);
    check({tag, "_err"},     o_err, 0);
    check({tag, "_busy"},    o_busy, 0);
    check({tag, "_sd_req"},  sd_request, 0);
    check({tag, "_sd_wren"}, sd_wren, 0);
    check({tag, "_sd_addr"}, sd_address, 0);
    check({tag, "_sd_data"}, sd_wdata, 0);
  endtask

  // Holds i_req until o_ack (bounded); returns at the sample point of the ack cycle.
  task automatic access(input logic w, input logic [22:0] a, input logic [3:0] b,
                        input logic [31:0] d, output bit got, output logic [31:0] rd,
                        output logic er, output int acc, output int ackc);
    int guard;
    guard = 0;
    while (o_busy && guard < 100) begin
      @(posedge i_clk);
      #1;
      guard++;
    end
    if (guard >= 100) check("idle_before_req", o_busy, 0);
    i_req = 1'b1;
    i_we = w;
    i_addr = a;
    i_be = b;
    i_wdata = d;
    acc = cyc;
    got = 1'b0;
    rd = '0;
    er = 1'b0;
    ackc = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge i_clk);
      #1;
      if (n == 0) check("busy_after_accept", o_busy, 1);
      if (o_ack) begin
        got = 1'b1;
        rd = o_rdata;
        er = o_err;
        ackc = cyc;
        break;
      end
    end
    i_req = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic w, input logic [22:0] a,
                               input logic [3:0] b, input logic [31:0] d);
    int          start;
    int          acc;
    int          ackc;
    int          exp_ack;
    int          nobs;
    bit          got;
    logic [31:0] rd;
    logic        er;
    logic [22:0] ea[$];
    logic [7:0]  ed[$];
    start = log_addr.size();
    for (int k = 0; k < 4; k++) begin
      if (!w || b[k]) begin
        ea.push_back({a[22:2], 2'(k)});
        ed.push_back(d[8*k +: 8]);
      end
    end
    access(w, a, b, d, got, rd, er, acc, ackc);
    last_acc = acc;
    last_ack = ackc;
    nobs = log_addr.size() - start;
    check({tag, "_ack"}, got, 1);
    check({tag, "_err"}, er, 0);
    check({tag, "_nreq"}, nobs, ea.size());
    exp_ack = acc + 2;
    for (int i = 0; i < ea.size() && i < nobs; i++) begin
      check({tag, "_req_addr"}, log_addr[start+i], ea[i]);
      check({tag, "_req_wren"}, log_wren[start+i], w);
      if (w) check({tag, "_req_data"}, log_data[start+i], ed[i]);
      exp_ack += log_lat[start+i] + 2;
    end
    check({tag, "_ack_cycle"}, ackc, exp_ack);
    for (int k = 0; k < 4; k++) begin
      if (w && b[k])  ref_mem[{a[9:2], 2'(k)}] = d[8*k +: 8];
      if (!w)         exp_rdata[8*k +: 8] = ref_mem[{a[9:2], 2'(k)}];
    end
    check({tag, "_rdata"}, rd, exp_rdata);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : main
    int          start;
    int          acc;
    int          ackc;
    int          nack;
    int          nbusy;
    bit          got;
    logic [31:0] rd;
    logic        er;
    logic [22:0] a;
    logic [31:0] d;
    logic        w;
    logic [3:0]  b;
    int          prev_ack;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    i_rst_n = 1'b0;
    i_req = 1'b0;
    i_we = 1'b0;
    i_addr = '0;
    i_be = '0;
    i_wdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    run_and_check("read", 1'b0, 23'h101, 4'h0, 32'h0);
    check("read_value", o_rdata, 32'h44332211);
    run_and_check("pwrite", 1'b1, 23'h200, 4'b1010, 32'hAABBCCDD);
    run_and_check("zero_be", 1'b1, 23'h208, 4'b0000, 32'h12345678);
    @(posedge i_clk);
    #1;
    check("ack_one_cycle", o_ack, 0);
    check("busy_falls", o_busy, 0);

    // Controller never answers: abort after TMO wait cycles with o_err.
    no_done = 1'b1;
    start = log_addr.size();
    access(1'b0, 23'h300, 4'h0, 32'h0, got, rd, er, acc, ackc);
    no_done = 1'b0;
    check("tmo_ack", got, 1);
    check("tmo_err", er, 1);
    check("tmo_ack_cycle", ackc, acc + 3 + TMO);
    check("tmo_nreq", log_addr.size() - start, 1);
    check("tmo_rdata", rd, exp_rdata);
    stray_req++;
    nack = 0;
    nbusy = 0;
    repeat (5) begin
      @(posedge i_clk);
      #1;
      if (o_ack) nack++;
      if (o_busy) nbusy++;
    end
    check("stray_done_ack", nack, 0);
    check("stray_done_busy", nbusy, 0);
    check("stray_done_rdata", o_rdata, exp_rdata);

    // Done on the last permitted wait cycle still completes normally.
    lat_min = TMO;
    lat_max = TMO;
    run_and_check("slow_done", 1'b0, 23'h104, 4'h0, 32'h0);

    // Reset during the lane-2 wait of a read.
    lat_min = 4;
    lat_max = 4;
    start = log_addr.size();
    i_req = 1'b1;
    i_we = 1'b0;
    i_addr = 23'h101;
    i_be = 4'h0;
    for (int n = 0; n < 100 && log_addr.size() < start + 3; n++) begin
      @(posedge i_clk);
      #1;
    end
    check("rst_reached_lane2", log_addr.size() - start, 3);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    i_req = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(posedge i_clk);
    #1;
    check_reset_values("held_rst");
    #4 i_rst_n = 1'b1;
    exp_rdata = '0;
    nack = 0;
    nbusy = 0;
    repeat (8) begin
      @(posedge i_clk);
      #1;
      if (o_ack) nack++;
      if (o_busy) nbusy++;
    end
    check("post_rst_ack", nack, 0);
    check("post_rst_busy", nbusy, 0);
    lat_min = 1;
    lat_max = 4;
    run_and_check("post_rst_read", 1'b0, 23'h101, 4'h0, 32'h0);

    // Back-to-back write then read of the same word.
    run_and_check("b2b_write", 1'b1, 23'h2A4, 4'hF, 32'hDEADBEEF);
    prev_ack = last_ack;
    run_and_check("b2b_read", 1'b0, 23'h2A4, 4'h0, 32'h0);
    check("b2b_accept_cycle", last_acc, prev_ack + 1);
    check("b2b_value", o_rdata, 32'hDEADBEEF);

    lat_max = TMO;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(1, 0));
      a = 23'($urandom);
      a[9:6] = 4'h0;
      b = 4'($urandom);
      d = $urandom;
      run_and_check("rand", w, a, b, d);
    end

    check("one_cycle_requests", long_pulses, 0);
    check("stable_sd_outputs", unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
